signal_async_pipe: RTL and testbench

- Parametrised successor to the single-request, fixed-two-stage increment responder.
- Accepts a request carrying data and a tag; returns data + INCR with the same tag after DEPTH cycles.
- Valid is carried per stage, so it deasserts when the request stream stops; it is not sticky.
- Adds output backpressure with a global pipeline stall; sits between a request producer and a response consumer in protocol test designs.

---
 rtl/signal_async_pipe.sv | 102 ++++++++++
 tb/tb_signal_async_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_async_pipe.sv
// Tagged increment pipeline: returns data + INCR with its tag after DEPTH cycles, with a global stall on output backpressure.
// Optional occupancy output enabled by defining SIGNAL_ASYNC_PIPE_OCCUPANCY_EN.
module signal_async_pipe #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 2,
  parameter int unsigned INCR   = 1,
  parameter int          TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              request,
  output logic              req_ready,
  input  logic [DATA_W-1:0] input_data,
  input  logic [TAG_W-1:0]  input_tag,
  output logic [DATA_W-1:0] final_resp,
  output logic [TAG_W-1:0]  final_resp_tag,
  output logic              final_resp_valid,
  input  logic              resp_ready
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  localparam logic [DATA_W-1:0] INCR_V = DATA_W'(INCR);

  // Modular add: the carry out of the top bit is intentionally dropped.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a);
    return a + INCR_V;
  endfunction

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic              stall;

  always_comb begin
    stall     = vld_q[DEPTH-1] & ~resp_ready;
    req_ready = ~stall;
  end

  // Stage 0 captures the incoming request; later stages shift, all frozen together on stall.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (!stall) begin
      vld_d[0]  = request;
      data_d[0] = add_wrap(input_data);
      tag_d[0]  = input_tag;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
        tag_d[k]  = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  // Last stage drives the response directly.
  assign final_resp       = data_q[DEPTH-1];
  assign final_resp_tag   = tag_q[DEPTH-1];
  assign final_resp_valid = vld_q[DEPTH-1];

`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  function automatic logic [OCC_W-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) n = n + OCC_W'(v[k]);
    return n;
  endfunction

  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb occ_d = count_valid(vld_d);

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_signal_async_pipe.sv
// Bench for signal_async_pipe: four configurations share one stimulus stream and are checked against
// an in-flight transaction scoreboard every cycle, plus hand-computed literal expectations.
module tb_signal_async_pipe;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset, request, resp_ready;
  logic [31:0] input_data;
  logic [3:0]  input_tag;

  logic        rv [NI];
  logic [31:0] rd [NI];
  logic [3:0]  rt [NI];
  logic        rr [NI];
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
  logic [1:0] occ0;
  logic [1:0] occ1;
  logic [2:0] occ2;
  logic       occ3;
`endif

  always #5 clk = ~clk;

  // Instance 0: DEPTH 2/INCR 1, 1: DEPTH 3/INCR 5, 2: DEPTH 4/INCR 1, 3: DEPTH 1/INCR 1
  signal_async_pipe #(.DATA_W(32), .DEPTH(2), .INCR(1), .TAG_W(4)) u_d2 (
    .clk(clk), .reset(reset), .request(request), .req_ready(rr[0]),
    .input_data(input_data), .input_tag(input_tag), .final_resp(rd[0]),
    .final_resp_tag(rt[0]), .final_resp_valid(rv[0]), .resp_ready(resp_ready)
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    , .occupancy(occ0)
`endif
  );
  signal_async_pipe #(.DATA_W(32), .DEPTH(3), .INCR(5), .TAG_W(4)) u_d3 (
    .clk(clk), .reset(reset), .request(request), .req_ready(rr[1]),
    .input_data(input_data), .input_tag(input_tag), .final_resp(rd[1]),
    .final_resp_tag(rt[1]), .final_resp_valid(rv[1]), .resp_ready(resp_ready)
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    , .occupancy(occ1)
`endif
  );
  signal_async_pipe #(.DATA_W(32), .DEPTH(4), .INCR(1), .TAG_W(4)) u_d4 (
    .clk(clk), .reset(reset), .request(request), .req_ready(rr[2]),
    .input_data(input_data), .input_tag(input_tag), .final_resp(rd[2]),
    .final_resp_tag(rt[2]), .final_resp_valid(rv[2]), .resp_ready(resp_ready)
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    , .occupancy(occ2)
`endif
  );
  signal_async_pipe #(.DATA_W(32), .DEPTH(1), .INCR(1), .TAG_W(4)) u_d1 (
    .clk(clk), .reset(reset), .request(request), .req_ready(rr[3]),
    .input_data(input_data), .input_tag(input_tag), .final_resp(rd[3]),
    .final_resp_tag(rt[3]), .final_resp_valid(rv[3]), .resp_ready(resp_ready)
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    , .occupancy(occ3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int dep_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] inc_of(input int i);
    return (i == 1) ? 32'd5 : 32'd1;
  endfunction

  // Scoreboard of in-flight accepted requests, oldest first; a request is visible
  // at the output once it has aged DEPTH unstalled edges.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          age;
  } ent_t;

  ent_t pend [NI][16];
  int   np   [NI];

  function automatic logic m_valid(input int i);
    return (np[i] > 0) && (pend[i][0].age == dep_of(i));
  endfunction

  task automatic mstep(input int i);
    logic ov;
    ov = m_valid(i);
    if (reset) begin
      np[i] = 0;
    end else if (!(ov && !resp_ready)) begin
      if (ov) begin
        for (int j = 0; j < np[i] - 1; j++) pend[i][j] = pend[i][j+1];
        np[i]--;
      end
      for (int j = 0; j < np[i]; j++) pend[i][j].age++;
      if (request) begin
        pend[i][np[i]].d   = input_data + inc_of(i);
        pend[i][np[i]].t   = input_tag;
        pend[i][np[i]].age = 1;
        np[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) mstep(i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic mv;
        mv = m_valid(i);
        check($sformatf("resp_valid[%0d]", i), 32'(rv[i]), 32'(mv));
        check($sformatf("req_ready[%0d]", i), 32'(rr[i]), 32'(!(mv && !resp_ready)));
        if (mv) begin
          check($sformatf("resp_data[%0d]", i), rd[i], pend[i][0].d);
          check($sformatf("resp_tag[%0d]", i), 32'(rt[i]), 32'(pend[i][0].t));
        end
      end
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
      check("occupancy[0]", 32'(occ0), 32'(np[0]));
      check("occupancy[1]", 32'(occ1), 32'(np[1]));
      check("occupancy[2]", 32'(occ2), 32'(np[2]));
      check("occupancy[3]", 32'(occ3), 32'(np[3]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic [31:0] d, input logic [3:0] t);
    request    = r;
    input_data = d;
    input_tag  = t;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) np[i] = 0;
    reset      = 1'b1;
    resp_ready = 1'b1;
    set_req(1'b0, 32'h0, 4'h0);
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_valid", 32'(rv[0]), 32'd0);
    check("reset_data", rd[0], 32'd0);
    check("reset_tag", 32'(rt[0]), 32'd0);
    check("reset_ready", 32'(rr[0]), 32'd1);
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    check("reset_occ", 32'(occ2), 32'd0);
`endif
    reset = 1'b0;

    // Single request, latency per depth, non-sticky valid
    set_req(1'b1, 32'h10, 4'd3);
    tick();
    set_req(1'b0, 32'h0, 4'd0);
    check("single_d1_valid", 32'(rv[3]), 32'd1);
    check("single_d1_data", rd[3], 32'h11);
    check("single_d2_early", 32'(rv[0]), 32'd0);
    tick();
    check("single_d2_valid", 32'(rv[0]), 32'd1);
    check("single_d2_data", rd[0], 32'h11);
    check("single_d2_tag", 32'(rt[0]), 32'd3);
    check("single_d1_gone", 32'(rv[3]), 32'd0);
    tick();
    check("single_d2_gone", 32'(rv[0]), 32'd0);
    check("single_d3_data", rd[1], 32'h15);
    tick();
    check("single_d4_data", rd[2], 32'h11);
    check("single_d3_gone", 32'(rv[1]), 32'd0);
    repeat (2) tick();

    // Wraparound
    set_req(1'b1, 32'hFFFF_FFFF, 4'hA);
    tick();
    set_req(1'b0, 32'h0, 4'd0);
    check("wrap_d1_data", rd[3], 32'h0);
    tick();
    check("wrap_d2_valid", 32'(rv[0]), 32'd1);
    check("wrap_d2_data", rd[0], 32'h0);
    check("wrap_d2_tag", 32'(rt[0]), 32'hA);
    tick();
    check("wrap_incr5_data", rd[1], 32'h4);
    repeat (3) tick();

    // Streaming with a bubble (checked on the DEPTH 3, INCR 5 instance)
    set_req(1'b1, 32'd1, 4'd1); tick();
    set_req(1'b1, 32'd2, 4'd2); tick();
    set_req(1'b0, 32'h55, 4'd9); tick();
    check("stream_first_data", rd[1], 32'd6);
    check("stream_first_tag", 32'(rt[1]), 32'd1);
    set_req(1'b1, 32'd4, 4'd4); tick();
    check("stream_second_data", rd[1], 32'd7);
    check("stream_second_tag", 32'(rt[1]), 32'd2);
    set_req(1'b0, 32'h0, 4'd0); tick();
    check("stream_bubble", 32'(rv[1]), 32'd0);
    tick();
    check("stream_last_valid", 32'(rv[1]), 32'd1);
    check("stream_last_data", rd[1], 32'd9);
    check("stream_last_tag", 32'(rt[1]), 32'd4);
    repeat (4) tick();

    // Backpressure (checked on the DEPTH 4 instance)
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h20 + 32'(i), 4'(5 + i));
      tick();
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
      check("bp_occ_fill", 32'(occ2), 32'(i + 1));
`endif
    end
    check("bp_head_valid", 32'(rv[2]), 32'd1);
    check("bp_head_data", rd[2], 32'h21);
    set_req(1'b1, 32'h99, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(rv[2]), 32'd1);
      check("bp_hold_data", rd[2], 32'h21);
      check("bp_hold_tag", 32'(rt[2]), 32'd5);
      check("bp_hold_ready", 32'(rr[2]), 32'd0);
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
      check("bp_hold_occ", 32'(occ2), 32'd4);
`endif
    end
    set_req(1'b0, 32'h0, 4'd0);
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_drain_data", rd[2], 32'h22 + 32'(i));
      check("bp_drain_tag", 32'(rt[2]), 32'(6 + i));
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
      check("bp_drain_occ", 32'(occ2), 32'(3 - i));
`endif
    end
    tick();
    check("bp_drain_empty", 32'(rv[2]), 32'd0);
`ifdef SIGNAL_ASYNC_PIPE_OCCUPANCY_EN
    check("bp_drain_occ0", 32'(occ2), 32'd0);
`endif
    repeat (5) tick();

    // Reset mid-flight discards in-flight requests
    set_req(1'b1, 32'h30, 4'd1); tick();
    set_req(1'b1, 32'h31, 4'd2); tick();
    set_req(1'b0, 32'h0, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("midrst_valid", 32'(rv[i]), 32'd0);
      check("midrst_ready", 32'(rr[i]), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_stale_d2", 32'(rv[0]), 32'd0);
      check("midrst_no_stale_d4", 32'(rv[2]), 32'd0);
    end
    set_req(1'b1, 32'h7, 4'd2); tick();
    set_req(1'b0, 32'h0, 4'd0);
    check("midrst_new_early", 32'(rv[0]), 32'd0);
    tick();
    check("midrst_new_valid", 32'(rv[0]), 32'd1);
    check("midrst_new_data", rd[0], 32'h8);
    check("midrst_new_tag", 32'(rt[0]), 32'd2);
    repeat (5) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
